sram_axi_bridge: RTL and testbench
==================================

Name: sram_axi_bridge

Overview:
- Shares a single AXI master port between the IF-stage inst_sram-like requester and the MEM-stage data_sram-like requester.
- Converts each req/addr_ok/data_ok transaction into one single-beat AXI transaction and returns the result to the issuing port.
- Data reads have priority over instruction fetch.
- Every accepted request is always completed. There is no cancel; IF discards unwanted data itself.

Parameters:
INST_ID, 4'd0, arid driven for instruction reads
DATA_ID, 4'd1, arid/awid driven for data accesses

Ports:
clk  in  1  clock
resetn  in  1  reset, asynchronous, active-low
inst_sram_req  in  1  fetch request (read-only port)
inst_sram_size  in  2  log2 bytes
inst_sram_addr  in  32  fetch address
inst_sram_addr_ok  out  1  request accepted this cycle
inst_sram_data_ok  out  1  fetch data valid this cycle
inst_sram_rdata  out  32  fetch data
data_sram_req  in  1  data request
data_sram_wr  in  1  1=write
data_sram_size  in  2  log2 bytes
data_sram_wstrb  in  4  byte enables
data_sram_addr  in  32  address
data_sram_wdata  in  32  write data
data_sram_addr_ok  out  1  request accepted this cycle
data_sram_data_ok  out  1  read data / write done
data_sram_rdata  out  32  read data
arid  out  4  read id
araddr  out  32  read address
arsize  out  3  {1'b0,size}
arvalid  out  1  read address valid
arready  in  1  slave accepts AR
rdata  in  32  read data
rvalid  in  1  read data valid
rready  out  1  master accepts R
awid  out  4  always DATA_ID
awaddr  out  32  write address
awsize  out  3  {1'b0,size}
awvalid  out  1  write address valid
awready  in  1  slave accepts AW
wdata  out  32  write data
wstrb  out  4  byte enables
wvalid  out  1  write data valid
wready  in  1  slave accepts W
bvalid  in  1  write response valid
bready  out  1  master accepts B

Behaviour:
- Reset:
  - resetn=0 asynchronously forces both FSMs to IDLE and clears all owner, done and latch registers.
  - All valid/ready/addr_ok/data_ok outputs are 0 during reset. rdata outputs are don't-care.
  - Reset mid-transaction abandons it; the AXI slave shares the same reset.
- All AXI transactions are single beat. len=0, burst=INCR, last=1 are tied off outside this block.
- Read FSM states RD_IDLE, RD_ADDR, RD_DATA:
  - RD_IDLE grant:
    - data read (data_req & ~data_wr) wins if allowed;
    - otherwise inst_req.
    - Data read is allowed only when the write FSM is in WR_IDLE and no data write is accepted in the same cycle.
  - On grant, the winner's addr_ok=1 combinationally that cycle. Owner, addr and size are latched, then -> RD_ADDR. The loser's addr_ok=0.
  - RD_ADDR: arvalid=1, arid=owner's ID. Stays until arready, then -> RD_DATA. arvalid never drops before the handshake.
  - RD_DATA: rready=1. On rvalid:
    - owner's data_ok=1 for exactly that cycle;
    - owner's rdata=rdata (combinational pass-through);
    - -> RD_IDLE.
  - Minimum latency with arready/rvalid immediate: accept at T, arvalid at T+1, data_ok at T+2. New acceptance is possible at T+3.
- Write FSM states WR_IDLE, WR_SEND, WR_RESP:
  - WR_IDLE: accepts data_req & data_wr unless the read FSM currently owns a data read (RD_ADDR/RD_DATA).
  - Writes have priority over a simultaneous data read only in the sense that both can never be requested at once (single request line).
  - On accept: data_addr_ok=1, addr/size/wstrb/wdata are latched, aw_done=w_done=0, -> WR_SEND.
  - WR_SEND: awvalid=~aw_done and wvalid=~w_done, driven independently.
    - Each handshake sets its done flag.
    - When both are done (including both in the same cycle) -> WR_RESP.
  - WR_RESP: bready=1. On bvalid, data_data_ok=1 for one cycle, -> WR_IDLE. bresp is ignored.
- Ordering:
  - The data port has at most one outstanding transaction, so its data_ok events are in order and never collide.
  - An inst read may be outstanding concurrently with a data write.
- data_ok is never asserted for a port with nothing outstanding. addr_ok is never asserted without the corresponding req.
- A data read arriving while the write FSM is busy is stalled (addr_ok=0) until the write FSM returns to WR_IDLE. It is then accepted in that same cycle if the read FSM is in RD_IDLE.

Test Plan:
- Inst fetch 0x1c000000, arready/rvalid immediate, rdata=0x02800400 -> inst_addr_ok at T, arvalid T+1 with arid=0, inst_data_ok T+2 with inst_rdata=0x02800400.
- inst_req and data read 0x00001000 both at T -> only data_addr_ok at T (arid=1). Inst is accepted in the cycle the read FSM returns to RD_IDLE, and both data_oks return in grant order.
- Data write 0x00002000, wdata=0xdeadbeef, wstrb=4'b0011; wready 3 cycles after awready -> awvalid drops after its handshake, wvalid held until wready, data_data_ok one cycle after bvalid.
- Data write pending in WR_RESP, then data read to the same address -> data_addr_ok stays 0 until the cycle after bvalid, then read proceeds. Inst fetch overlapping the write completes normally.
- arready held 0 for 5 cycles -> arvalid/araddr stable for all 5 cycles, no addr_ok to any port meanwhile.
- resetn pulled low while in RD_DATA -> outputs go 0 immediately, no data_ok. After release, fetch 0x1c000000 starts from RD_IDLE.

Source files
------------

// File: rtl/sram_axi_bridge.sv
// sram_axi_bridge: shares one AXI master between an inst_sram-like fetch port and a data_sram-like port
// Independent read and write FSMs; each accepted request becomes one single-beat AXI transaction.
module sram_axi_bridge #(
    parameter logic [3:0] INST_ID = 4'd0,
    parameter logic [3:0] DATA_ID = 4'd1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_sram_req,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);
    typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA} rd_state_t;
    typedef enum logic [1:0] {WR_IDLE, WR_SEND, WR_RESP} wr_state_t;

    rd_state_t   rd_state, rd_next;
    wr_state_t   wr_state, wr_next;
    logic        rd_owner;
    logic [31:0] rd_addr;
    logic [1:0]  rd_size;
    logic [31:0] wr_addr, wr_data;
    logic [1:0]  wr_size;
    logic [3:0]  wr_strb;
    logic        aw_done, w_done;
    logic        wr_accept, data_rd_grant, inst_grant, rd_fire;

    // rd_owner=1 marks a data read; a data write must not start while one is in flight
    always_comb begin
        wr_accept = resetn && wr_state == WR_IDLE && data_sram_req && data_sram_wr
                    && !(rd_state != RD_IDLE && rd_owner);
        data_rd_grant = resetn && rd_state == RD_IDLE && wr_state == WR_IDLE
                        && data_sram_req && !data_sram_wr && !wr_accept;
        inst_grant = resetn && rd_state == RD_IDLE && inst_sram_req && !data_rd_grant;
        rd_fire = rd_state == RD_DATA && rvalid;
        rd_next = rd_state == RD_IDLE ? ((data_rd_grant || inst_grant) ? RD_ADDR : RD_IDLE)
                : rd_state == RD_ADDR ? (arready ? RD_DATA : RD_ADDR)
                : (rvalid ? RD_IDLE : RD_DATA);
        wr_next = wr_state == WR_IDLE ? (wr_accept ? WR_SEND : WR_IDLE)
                : wr_state == WR_SEND ? (((aw_done || awready) && (w_done || wready)) ? WR_RESP : WR_SEND)
                : (bvalid ? WR_IDLE : WR_RESP);
        inst_sram_addr_ok = inst_grant;
        data_sram_addr_ok = data_rd_grant || wr_accept;
        inst_sram_data_ok = rd_fire && !rd_owner;
        data_sram_data_ok = (rd_fire && rd_owner) || (wr_state == WR_RESP && bvalid);
        inst_sram_rdata = rdata;
        data_sram_rdata = rdata;
        arid = rd_owner ? DATA_ID : INST_ID;
        araddr = rd_addr;
        arsize = {1'b0, rd_size};
        arvalid = rd_state == RD_ADDR;
        rready = rd_state == RD_DATA;
        awid = DATA_ID;
        awaddr = wr_addr;
        awsize = {1'b0, wr_size};
        awvalid = wr_state == WR_SEND && !aw_done;
        wdata = wr_data;
        wstrb = wr_strb;
        wvalid = wr_state == WR_SEND && !w_done;
        bready = wr_state == WR_RESP;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_state <= RD_IDLE;
            wr_state <= WR_IDLE;
        end else begin
            rd_state <= rd_next;
            wr_state <= wr_next;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_owner <= 1'b0;
            rd_addr  <= '0;
            rd_size  <= '0;
            wr_addr  <= '0;
            wr_data  <= '0;
            wr_size  <= '0;
            wr_strb  <= '0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
        end else begin
            if (data_rd_grant || inst_grant) begin
                rd_owner <= data_rd_grant;
                rd_addr  <= data_rd_grant ? data_sram_addr : inst_sram_addr;
                rd_size  <= data_rd_grant ? data_sram_size : inst_sram_size;
            end
            if (wr_accept) begin
                wr_addr <= data_sram_addr;
                wr_data <= data_sram_wdata;
                wr_size <= data_sram_size;
                wr_strb <= data_sram_wstrb;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else if (wr_state == WR_SEND) begin
                aw_done <= aw_done || awready;
                w_done  <= w_done || wready;
            end
        end
    end
endmodule

// File: tb/tb_sram_axi_bridge.sv
// tb_sram_axi_bridge: random requesters and AXI slave with a transaction-level scoreboard
module tb_sram_axi_bridge;
    localparam logic [3:0] INST_ID = 4'd0;
    localparam logic [3:0] DATA_ID = 4'd1;

    logic clk = 1'b0, resetn = 1'b0;
    always #5 clk = ~clk;

    logic        inst_sram_req = 0, inst_sram_addr_ok, inst_sram_data_ok;
    logic [1:0]  inst_sram_size = 0;
    logic [31:0] inst_sram_addr = 0, inst_sram_rdata;
    logic        data_sram_req = 0, data_sram_wr = 0, data_sram_addr_ok, data_sram_data_ok;
    logic [1:0]  data_sram_size = 0;
    logic [3:0]  data_sram_wstrb = 0;
    logic [31:0] data_sram_addr = 0, data_sram_wdata = 0, data_sram_rdata;
    logic [3:0]  arid, awid, wstrb;
    logic [31:0] araddr, awaddr, wdata, rdata = 0;
    logic [2:0]  arsize, awsize;
    logic        arvalid, rready, awvalid, wvalid, bready;
    logic        arready = 0, rvalid = 0, awready = 0, wready = 0, bvalid = 0;

    sram_axi_bridge #(.INST_ID(INST_ID), .DATA_ID(DATA_ID)) dut (
        .clk(clk), .resetn(resetn),
        .inst_sram_req(inst_sram_req), .inst_sram_size(inst_sram_size), .inst_sram_addr(inst_sram_addr),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
        .data_sram_wstrb(data_sram_wstrb), .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
        .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    typedef struct packed {logic wr; logic [31:0] val;} dexp_t;

    int checks = 0, passes = 0, cyc = 0;
    int ar_pct = 100, r_pct = 100, aw_pct = 100, w_pct = 100, b_pct = 100;
    int t_iaok = 0, t_arhs = 0, t_idok = 0, t_ddok = 0;
    logic m_rd_busy = 0, m_rd_data = 0, m_ar_seen = 0, m_wr_busy = 0, m_aw_seen = 0, m_w_seen = 0;
    logic i_acc = 0, d_acc = 0, e_iaok, e_daok, r_hs, b_hs;
    logic p_ar_stall = 0, p_aw_stall = 0, p_w_stall = 0;
    logic [31:0] p_araddr, p_awaddr, p_wdata, last_irdata = 0, last_drdata = 0;
    logic [31:0] e_araddr = 0, e_waddr = 0, e_wdata = 0, s_raddr = 0, s_waddr = 0, s_wdata = 0;
    logic [3:0]  e_arid = 0, e_wstrb = 0, s_wstrb = 0;
    logic [2:0]  e_arsize = 0, e_awsize = 0;
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] s_mem [logic [31:0]];
    dexp_t       data_q [$];
    logic [31:0] inst_q [$];
    dexp_t       d;

    function automatic logic [31:0] mem_init(input logic [31:0] a);
        return a ^ 32'h1e800400;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] s);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
    endfunction

    function automatic logic [31:0] s_rd(input logic [31:0] a);
        return s_mem.exists(a) ? s_mem[a] : mem_init(a);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Monitor and scoreboard: expectations come from outstanding-transaction bookkeeping
    always @(negedge clk) begin
        if (!resetn) begin
            m_rd_busy = 0; m_rd_data = 0; m_ar_seen = 0; m_wr_busy = 0; m_aw_seen = 0; m_w_seen = 0;
            i_acc = 0; d_acc = 0; p_ar_stall = 0; p_aw_stall = 0; p_w_stall = 0;
            data_q.delete(); inst_q.delete();
        end else begin
            cyc++;
            r_hs = rvalid & rready;
            b_hs = bvalid & bready;
            e_daok = data_sram_req & ~m_wr_busy & (data_sram_wr ? ~(m_rd_busy & m_rd_data) : ~m_rd_busy);
            e_iaok = inst_sram_req & ~m_rd_busy & ~(e_daok & ~data_sram_wr);
            chk("addr_ok", {inst_sram_addr_ok, data_sram_addr_ok}, {e_iaok, e_daok});
            chk("axi_ctrl", {arvalid, rready, awvalid, wvalid, bready},
                {m_rd_busy & ~m_ar_seen, m_rd_busy & m_ar_seen, m_wr_busy & ~m_aw_seen,
                 m_wr_busy & ~m_w_seen, m_wr_busy & m_aw_seen & m_w_seen});
            chk("data_ok", {inst_sram_data_ok, data_sram_data_ok}, {r_hs & ~m_rd_data, (r_hs & m_rd_data) | b_hs});
            if (inst_sram_data_ok && inst_q.size() > 0) begin
                t_idok = cyc;
                last_irdata = inst_sram_rdata;
                chk("inst_rdata", inst_sram_rdata, inst_q.pop_front());
            end
            if (data_sram_data_ok && data_q.size() > 0) begin
                t_ddok = cyc;
                d = data_q.pop_front();
                chk("data_ok_kind", b_hs, d.wr);
                if (!d.wr) begin
                    last_drdata = data_sram_rdata;
                    chk("data_rdata", data_sram_rdata, d.val);
                end
            end
            if (p_ar_stall) chk("ar_stable", {arvalid, araddr}, {1'b1, p_araddr});
            if (p_aw_stall) chk("aw_stable", {awvalid, awaddr}, {1'b1, p_awaddr});
            if (p_w_stall) chk("w_stable", {wvalid, wdata}, {1'b1, p_wdata});
            p_ar_stall = arvalid & ~arready; p_araddr = araddr;
            p_aw_stall = awvalid & ~awready; p_awaddr = awaddr;
            p_w_stall = wvalid & ~wready; p_wdata = wdata;
            if (arvalid && arready) begin
                t_arhs = cyc;
                chk("ar_chan", {arid, arsize, araddr}, {e_arid, e_arsize, e_araddr});
                s_raddr = araddr;
                m_ar_seen = 1;
            end
            if (awvalid && awready) begin
                chk("aw_chan", {awid, awsize, awaddr}, {DATA_ID, e_awsize, e_waddr});
                s_waddr = awaddr;
                m_aw_seen = 1;
            end
            if (wvalid && wready) begin
                chk("w_chan", {wstrb, wdata}, {e_wstrb, e_wdata});
                s_wdata = wdata;
                s_wstrb = wstrb;
                m_w_seen = 1;
            end
            if (b_hs) begin
                s_mem[s_waddr] = merge(s_rd(s_waddr), s_wdata, s_wstrb);
                m_wr_busy = 0;
            end
            if (r_hs) m_rd_busy = 0;
            i_acc = inst_sram_addr_ok;
            d_acc = data_sram_addr_ok;
            if (inst_sram_addr_ok) begin
                t_iaok = cyc;
                e_arid = INST_ID; e_araddr = inst_sram_addr; e_arsize = {1'b0, inst_sram_size};
                inst_q.push_back(ref_rd(inst_sram_addr));
                m_rd_busy = 1; m_rd_data = 0; m_ar_seen = 0;
            end
            if (data_sram_addr_ok) begin
                if (data_sram_wr) begin
                    e_waddr = data_sram_addr; e_wdata = data_sram_wdata; e_wstrb = data_sram_wstrb;
                    e_awsize = {1'b0, data_sram_size};
                    ref_mem[data_sram_addr] = merge(ref_rd(data_sram_addr), data_sram_wdata, data_sram_wstrb);
                    data_q.push_back(dexp_t'({1'b1, 32'h0}));
                    m_wr_busy = 1; m_aw_seen = 0; m_w_seen = 0;
                end else begin
                    e_arid = DATA_ID; e_araddr = data_sram_addr; e_arsize = {1'b0, data_sram_size};
                    data_q.push_back(dexp_t'({1'b0, ref_rd(data_sram_addr)}));
                    m_rd_busy = 1; m_rd_data = 1; m_ar_seen = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (i_acc) inst_sram_req = 0;
        if (d_acc) data_sram_req = 0;
        arready = $urandom_range(99) < ar_pct;
        awready = $urandom_range(99) < aw_pct;
        wready = $urandom_range(99) < w_pct;
        if (!(m_rd_busy && m_ar_seen)) rvalid = 0;
        else if (!rvalid && $urandom_range(99) < r_pct) begin
            rvalid = 1;
            rdata = s_rd(s_raddr);
        end
        if (!(m_wr_busy && m_aw_seen && m_w_seen)) bvalid = 0;
        else if (!bvalid && $urandom_range(99) < b_pct) bvalid = 1;
    endtask

    task automatic inst_req_t(input logic [31:0] a);
        inst_sram_req = 1; inst_sram_addr = a; inst_sram_size = 2'd2;
    endtask

    task automatic data_req_t(input logic wr, input logic [31:0] a, input logic [31:0] dv, input logic [3:0] s);
        data_sram_req = 1; data_sram_wr = wr; data_sram_addr = a; data_sram_wdata = dv;
        data_sram_wstrb = s; data_sram_size = 2'd2;
    endtask

    task automatic wait_quiet(input int lim);
        int n = 0;
        while ((inst_sram_req || data_sram_req || m_rd_busy || m_wr_busy) && n < lim) begin
            step();
            n++;
        end
        chk("drain_timeout", n < lim, 1'b1);
    endtask

    task automatic set_pct(input int v);
        ar_pct = v; r_pct = v; aw_pct = v; w_pct = v; b_pct = v;
    endtask

    task automatic do_reset();
        #2;
        resetn = 0;
        inst_sram_req = 1; inst_sram_addr = 32'h1c000000; data_sram_req = 1; data_sram_wr = 0;
        rvalid = 1; bvalid = 1; arready = 1; awready = 1; wready = 1;
        #1;
        chk("reset_outputs", {arvalid, rready, awvalid, wvalid, bready, inst_sram_addr_ok,
            inst_sram_data_ok, data_sram_addr_ok, data_sram_data_ok}, 9'd0);
        inst_sram_req = 0; data_sram_req = 0;
        rvalid = 0; bvalid = 0; arready = 0; awready = 0; wready = 0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1;
    endtask

    task automatic fetch_check();
        set_pct(100);
        inst_req_t(32'h1c000000);
        wait_quiet(50);
        chk("lat_arvalid", t_arhs - t_iaok, 1);
        chk("lat_data_ok", t_idok - t_iaok, 2);
        chk("fetch_rdata", last_irdata, 32'h02800400);
    endtask

    initial begin
        int n;
        do_reset();
        fetch_check();
        // simultaneous fetch and data read: data wins, returns first
        inst_req_t(32'h1c000040);
        data_req_t(1'b0, 32'h00001000, 32'h0, 4'h0);
        wait_quiet(100);
        chk("grant_order", t_ddok < t_idok, 1'b1);
        // write whose W channel lags AW
        w_pct = 0;
        data_req_t(1'b1, 32'h00002000, 32'hdeadbeef, 4'b0011);
        repeat (4) step();
        w_pct = 100;
        wait_quiet(50);
        // write parked in response phase; read to same address waits, fetch overlaps
        b_pct = 0;
        data_req_t(1'b1, 32'h00002000, 32'h12345678, 4'b1100);
        repeat (4) step();
        data_req_t(1'b0, 32'h00002000, 32'h0, 4'h0);
        inst_req_t(32'h1c000080);
        repeat (6) step();
        chk("read_stalled", data_sram_req, 1'b1);
        b_pct = 100;
        wait_quiet(50);
        chk("merged_read", last_drdata, 32'h1234beef);
        // AR stall with a data read queued behind it
        ar_pct = 0;
        inst_req_t(32'h1c0000c0);
        step();
        data_req_t(1'b0, 32'h00002004, 32'h0, 4'h0);
        repeat (5) step();
        ar_pct = 100;
        wait_quiet(50);
        // reset while waiting for R
        r_pct = 0;
        inst_req_t(32'h1c000100);
        n = 0;
        while (!(m_rd_busy && m_ar_seen) && n < 20) begin
            step();
            n++;
        end
        chk("reach_rd_data", n < 20, 1'b1);
        do_reset();
        fetch_check();
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) begin
                ar_pct = 100 - 30 * int'($urandom_range(2));
                r_pct = 100 - 30 * int'($urandom_range(2));
                aw_pct = 100 - 30 * int'($urandom_range(2));
                w_pct = 100 - 30 * int'($urandom_range(2));
                b_pct = 100 - 30 * int'($urandom_range(2));
            end
            step();
            if (!inst_sram_req && $urandom_range(99) < 35)
                inst_req_t(32'h1c000000 + 32'($urandom_range(63)) * 4);
            if (!data_sram_req && $urandom_range(99) < 35) begin
                data_req_t(1'($urandom_range(1)), 32'h00002000 + 32'($urandom_range(7)) * 4,
                           $urandom, 4'($urandom_range(15)));
                data_sram_size = 2'($urandom_range(2));
            end
        end
        set_pct(100);
        wait_quiet(500);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
